// File: rtl/to_save.sv
// to_save: captures bytes from an 8-bit character bus into three strobe-selected
// slots and flags printable captures (YP) and completed ESC '[' final
// sequences (YC).
// Optional build macro TO_SAVE_SYNC_EN adds a 2-flop synchroniser on each
// strobe ahead of edge detection, which adds two cycles of latency.
module to_save #(
  parameter logic [7:0] ESC_BYTE = 8'h1B,
  parameter logic [7:0] CSI_BYTE = 8'h5B,
  parameter logic [7:0] FINAL_LO = 8'h40,
  parameter logic [7:0] FINAL_HI = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inp,
  input  logic       ESC1,
  input  logic       ESC2,
  input  logic       ESC3,
  output logic       YP,
  output logic       YC
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NSLOT  = 3;
  localparam logic [DATA_W-1:0] PRINT_LO = 8'h20;
  localparam logic [DATA_W-1:0] PRINT_HI = 8'h7E;

  logic [NSLOT-1:0]             esc_raw;
  logic [NSLOT-1:0]             esc_s;
  logic [NSLOT-1:0]             esc_q;
  logic [NSLOT-1:0]             hit;
  logic [NSLOT-1:0][DATA_W-1:0] slot;
  logic [NSLOT-1:0][DATA_W-1:0] slot_n;
  logic [NSLOT-1:0]             valid;
  logic [NSLOT-1:0]             valid_n;
  logic                         yp_n;
  logic                         yc_n;

  assign esc_raw = {ESC3, ESC2, ESC1};

`ifdef TO_SAVE_SYNC_EN
  logic [NSLOT-1:0] sync1;
  logic [NSLOT-1:0] sync2;

  // Two-flop synchroniser for strobes arriving from another clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= esc_raw;
      sync2 <= sync1;
    end
  end

  assign esc_s = sync2;
`else
  assign esc_s = esc_raw;
`endif

  // Rising-edge detect: a held strobe captures only once
  assign hit = esc_s & ~esc_q;

  // Next-state slot contents, printable flag and command match
  always_comb begin
    slot_n  = slot;
    valid_n = valid;
    yp_n    = 1'b0;
    yc_n    = 1'b0;
    for (int k = 0; k < int'(NSLOT); k++) begin
      if (hit[k]) begin
        slot_n[k]  = inp;
        valid_n[k] = 1'b1;
      end
    end
    // All simultaneous captures see the same byte, so one range test suffices
    yp_n = (|hit) && (inp >= PRINT_LO) && (inp <= PRINT_HI);
    yc_n = (|hit) && (&valid_n)
           && (slot_n[0] == ESC_BYTE)
           && (slot_n[1] == CSI_BYTE)
           && (slot_n[2] >= FINAL_LO)
           && (slot_n[2] <= FINAL_HI);
    // A recognised command consumes the slots; data stays for inspection
    if (yc_n) begin
      valid_n = '0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      esc_q <= '0;
      slot  <= '0;
      valid <= '0;
      YP    <= 1'b0;
      YC    <= 1'b0;
    end else begin
      esc_q <= esc_s;
      slot  <= slot_n;
      valid <= valid_n;
      YP    <= yp_n;
      YC    <= yc_n;
    end
  end

endmodule

// File: tb/tb_to_save.sv
// Directed self-checking bench for to_save: reset behaviour, printable
// boundaries, held strobes, out-of-order command assembly, final-byte range,
// simultaneous strobes and reset in the middle of a sequence.
module tb_to_save;

`ifdef TO_SAVE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inp;
  logic       ESC1, ESC2, ESC3;
  logic       YP, YC;

  int checks = 0;
  int errors = 0;

  to_save dut (
    .clk  (clk),
    .rst  (rst),
    .inp  (inp),
    .ESC1 (ESC1),
    .ESC2 (ESC2),
    .ESC3 (ESC3),
    .YP   (YP),
    .YC   (YC)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_esc(input int k, input logic v);
    case (k)
      1: ESC1 = v;
      2: ESC2 = v;
      default: ESC3 = v;
    endcase
  endtask

  // Raise strobe k with byte b, check the pulse cycle, then check it ends
  task automatic pulse(input string tag, input int k, input logic [7:0] b,
                       input logic eyp, input logic eyc);
    inp = b;
    set_esc(k, 1'b1);
    repeat (LAT) step();
    chk({tag, "_yp"}, {7'd0, YP}, {7'd0, eyp});
    chk({tag, "_yc"}, {7'd0, YC}, {7'd0, eyc});
    set_esc(k, 1'b0);
    step();
    chk({tag, "_yp_end"}, {7'd0, YP}, 8'd0);
    chk({tag, "_yc_end"}, {7'd0, YC}, 8'd0);
    step();
  endtask

  initial begin
    rst = 1'b1; inp = 8'h00; ESC1 = 1'b0; ESC2 = 1'b0; ESC3 = 1'b0;
    step(); step();

    // Reset held with all strobes high and a printable byte: nothing happens
    ESC1 = 1'b1; ESC2 = 1'b1; ESC3 = 1'b1; inp = 8'h41;
    step();
    chk("rst0_yp", {7'd0, YP}, 8'd0);
    chk("rst0_yc", {7'd0, YC}, 8'd0);
    step();
    chk("rst1_yp", {7'd0, YP}, 8'd0);
    chk("rst1_yc", {7'd0, YC}, 8'd0);
    chk("rst_valid", {5'd0, dut.valid}, 8'd0);
    rst = 1'b0; ESC1 = 1'b0; ESC2 = 1'b0; ESC3 = 1'b0;
    repeat (LAT + 1) step();
    chk("post_rst_yp", {7'd0, YP}, 8'd0);

    // Re-raise after reset captures normally; 8'h20 is the lowest printable
    pulse("p20", 1, 8'h20, 1'b1, 1'b0);

    // Non-printable capture
    pulse("np08", 1, 8'h08, 1'b0, 1'b0);
    chk("slot1_08", dut.slot[0], 8'h08);

    // Held strobe captures once only
    inp = 8'h41; ESC1 = 1'b1;
    repeat (LAT) step();
    chk("hold_first", {7'd0, YP}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_again", {7'd0, YP}, 8'd0);
    end
    ESC1 = 1'b0;
    step(); step();

    // Printable range boundaries
    pulse("np7f", 2, 8'h7F, 1'b0, 1'b0);
    pulse("np80", 3, 8'h80, 1'b0, 1'b0);
    pulse("np1f", 3, 8'h1F, 1'b0, 1'b0);
    pulse("p7e",  3, 8'h7E, 1'b1, 1'b0);

    // Command assembled out of order: final, CSI, then ESC
    pulse("cmd_fin", 3, 8'h41, 1'b1, 1'b0);
    pulse("cmd_csi", 2, 8'h5B, 1'b1, 1'b0);
    pulse("cmd_esc", 1, 8'h1B, 1'b0, 1'b1);
    // Valid bits were consumed: a lone ESC must not re-match
    pulse("cleared", 1, 8'h1B, 1'b0, 1'b0);

    // Final byte at upper bound completes
    pulse("hi_csi", 2, 8'h5B, 1'b1, 1'b0);
    pulse("hi_fin", 3, 8'h7E, 1'b1, 1'b1);

    // Final byte just outside range, then lower bound
    pulse("lo_esc", 1, 8'h1B, 1'b0, 1'b0);
    pulse("lo_csi", 2, 8'h5B, 1'b1, 1'b0);
    pulse("fin3f",  3, 8'h3F, 1'b1, 1'b0);
    pulse("fin7f",  3, 8'h7F, 1'b0, 1'b0);
    pulse("fin40",  3, 8'h40, 1'b1, 1'b1);

    // Simultaneous strobes all capture the same byte
    inp = 8'h1B; ESC1 = 1'b1; ESC2 = 1'b1; ESC3 = 1'b1;
    repeat (LAT) step();
    chk("sim_yp", {7'd0, YP}, 8'd0);
    chk("sim_yc", {7'd0, YC}, 8'd0);
    ESC1 = 1'b0; ESC2 = 1'b0; ESC3 = 1'b0;
    step(); step();
    chk("sim_slot3", dut.slot[2], 8'h1B);
    pulse("sim_csi", 2, 8'h5B, 1'b1, 1'b0);
    pulse("sim_fin", 3, 8'h41, 1'b1, 1'b1);

    // Reset in the middle of a sequence discards partial captures
    pulse("mid_esc", 1, 8'h1B, 1'b0, 1'b0);
    pulse("mid_csi", 2, 8'h5B, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    pulse("mid_fin", 3, 8'h41, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/to_save.md
Name:
to_save

Overview:
- Capture and recognise short terminal escape sequences from an 8-bit character bus.
- Three independent strobe inputs (ESC1..ESC3) each latch the current `inp` byte into their own slot.
- Block reports printable-character captures (YP) and completed CSI control sequences ESC '[' final (YC).
- Sits between a keyboard/UART character source and the command/save logic.

Parameters:
- ESC_BYTE, 8'h1B, value slot 1 must hold for a command match.
- CSI_BYTE, 8'h5B, value slot 2 must hold for a command match.
- FINAL_LO, 8'h40, lowest legal final byte in slot 3 (inclusive).
- FINAL_HI, 8'h7E, highest legal final byte in slot 3 (inclusive).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- inp  input  8  character byte; sampled when a strobe edge is detected.
- ESC1  input  1  level strobe; rising edge captures inp into slot 1.
- ESC2  input  1  level strobe; rising edge captures inp into slot 2.
- ESC3  input  1  level strobe; rising edge captures inp into slot 3.
- YP  output  1  one-cycle pulse: a printable byte (8'h20..8'h7E) was captured.
- YC  output  1  one-cycle pulse: slots 1..3 form a complete command.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (`rst`=1 at a clk edge):
  - slot data = 8'h00, slot valid bits = 0;
  - strobe history registers = 0;
  - YP = 0, YC = 0.
  - Reset overrides any edge in the same cycle.
  - Reset mid-sequence discards all partial captures.
- Edge detect:
  - Each ESCk is registered into esc_q[k].
  - edge[k] = ESCk & ~esc_q[k], evaluated at the sampling edge.
  - A strobe held high captures exactly once; a new capture needs a low sample first.
- Capture, at the clk edge where edge[k]=1:
  - slot[k] <= inp and valid[k] <= 1;
  - an earlier value in the slot is overwritten.
- Simultaneous edges on several ESCk in one cycle: all flagged slots capture the same `inp` in that cycle.
- YP (registered):
  - YP <= 1 in the cycle following an edge when any byte captured at that edge lies in 8'h20..8'h7E inclusive;
  - otherwise YP <= 0. 8'h7F and bytes >= 8'h80 are non-printable.
- YC (registered), computed from the next-state slot contents:
  - YC <= 1 when all three valid bits are set, slot1==ESC_BYTE, slot2==CSI_BYTE, FINAL_LO<=slot3<=FINAL_HI, and at least one capture occurred this cycle;
  - otherwise YC <= 0.
  - When YC is set, all valid bits clear in the same edge; slot data is retained.
- Capture order is free: slots may be filled in any order; the match is evaluated on every capture.
- Latency: YP and YC assert exactly 1 clk after the edge where the strobe is first sampled high; each pulse lasts 1 cycle.
- `inp` must be stable from the strobe's rising edge until capture.

Optional Feature:
- Macro: TO_SAVE_SYNC_EN.
- Defined:
  - each ESCk first passes a 2-flop synchroniser before esc_q edge detection;
  - capture and YP/YC occur 2 cycles later than baseline (3 clk after the first high sample);
  - `inp` must stay stable during that window.
- Undefined: no synchroniser; ESCk feeds the edge detector directly (baseline latency 1).

Test Plan:
- Reset: assert `rst` for 2 cycles with ESC1..3=1 -> YP=0, YC=0, no capture; a later release/re-raise of ESC1 captures normally.
- Non-printable: `inp`=8'h08, raise ESC1 -> slot1=8'h08, YP stays 0, YC 0; then holding ESC1 high produces no further activity.
- Printable: `inp`=8'h7E, pulse ESC3 -> YP=1 for exactly one cycle, one cycle after the edge; YC 0.
- Command, any order:
  - `inp`=8'h41 on ESC3 -> YP=1; `inp`=8'h5B on ESC2 -> YP=1.
  - `inp`=8'h1B on ESC1 -> YC=1 for one cycle, YP=0; valid bits then cleared.
- Simultaneous: `inp`=8'h1B, ESC1, ESC2 and ESC3 rise in the same cycle -> all slots = 8'h1B, YP=0, YC=0 (slot2 != 8'h5B).
- Reset mid-sequence: capture 8'h1B on ESC1 and 8'h5B on ESC2, pulse `rst`, then capture 8'h41 on ESC3 -> YC stays 0.
